// File: rtl/shift_add_multiplier.sv
// Sequential unsigned shift-and-add multiplier with valid/ready handshakes on operands and product.
// Optional macro SHIFT_ADD_MULTIPLIER_EARLY_TERM_EN: zero operands bypass BUSY and complete in one cycle.
module shift_add_multiplier #(
  parameter int unsigned WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product
);

  localparam int unsigned PW    = 2 * WIDTH;
  localparam int unsigned SW    = WIDTH + 1;
  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state, state_next;
  logic [WIDTH-1:0]   mcand, mcand_next;
  logic [WIDTH-1:0]   acc, acc_next;
  logic [WIDTH-1:0]   mq, mq_next;
  logic [CNT_W-1:0]   count, count_next;
  logic [PW-1:0]      product_next;
  logic [SW-1:0]      sum_ext;
  logic [PW-1:0]      step;

  // Adder keeps its carry-out as the top bit, which lands in the acc MSB after the shift.
  always_comb begin
    sum_ext = mq[0] ? (SW'(acc) + SW'(mcand)) : SW'(acc);
    step    = {sum_ext, mq[WIDTH-1:1]};
  end

  always_comb begin
    state_next   = state;
    mcand_next   = mcand;
    acc_next     = acc;
    mq_next      = mq;
    count_next   = count;
    product_next = product;
    case (state)
      IDLE: begin
        if (in_valid) begin
          mcand_next = a;
          mq_next    = b;
          acc_next   = '0;
          count_next = CNT_W'(WIDTH - 1);
          state_next = BUSY;
`ifdef SHIFT_ADD_MULTIPLIER_EARLY_TERM_EN
          if ((a == '0) || (b == '0)) begin
            product_next = '0;
            state_next   = DONE;
          end
`endif
        end
      end
      BUSY: begin
        {acc_next, mq_next} = step;
        if (count == '0) begin
          product_next = step;
          state_next   = DONE;
        end else begin
          count_next = count - CNT_W'(1);
        end
      end
      DONE: begin
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Handshake flags are registered from the next state so they track it cycle-exactly.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      mcand     <= '0;
      acc       <= '0;
      mq        <= '0;
      count     <= '0;
      product   <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      state     <= state_next;
      mcand     <= mcand_next;
      acc       <= acc_next;
      mq        <= mq_next;
      count     <= count_next;
      product   <= product_next;
      in_ready  <= (state_next == IDLE);
      out_valid <= (state_next == DONE);
    end
  end

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Directed self-checking bench for shift_add_multiplier at WIDTH=4.
module tb_shift_add_multiplier;

  localparam int unsigned W = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] product;

  int total = 0;
  int bad   = 0;

  shift_add_multiplier #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int exp_lat(input logic [W-1:0] x, input logic [W-1:0] y);
`ifdef SHIFT_ADD_MULTIPLIER_EARLY_TERM_EN
    return ((x == '0) || (y == '0)) ? 0 : int'(W);
`else
    return int'(W);
`endif
  endfunction

  // Waits for out_valid, returning the number of edges after the acceptance edge.
  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic do_mul(input logic [W-1:0] x, input logic [W-1:0] y, input logic [2*W-1:0] exp);
    int n;
    int lat;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) check("rdy_timeout", 32'(in_ready), 32'd1);
    a = x; b = y; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_valid(lat);
    check("lat", 32'(lat), 32'(exp_lat(x, y)));
    check("prod", 32'(product), 32'(exp));
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("ov_clr", 32'(out_valid), 32'd0);
    check("ir_set", 32'(in_ready), 32'd1);
  endtask

  initial begin
    int lat;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    #2;
    check("rst_ir", 32'(in_ready), 32'd1);
    check("rst_ov", 32'(out_valid), 32'd0);
    check("rst_prod", 32'(product), 32'd0);
    #10 reset = 1'b0;
    @(posedge clk); #1;

    // Max operands exercise the adder carry-out.
    do_mul(4'd15, 4'd15, 8'd225);

    // Consumer stall: product and out_valid must hold.
    a = 4'd7; b = 4'd3; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_valid(lat);
    check("stall_lat", 32'(lat), 32'(W));
    for (int i = 0; i < 10; i++) begin
      check("stall_ov", 32'(out_valid), 32'd1);
      check("stall_prod", 32'(product), 32'd21);
      check("stall_ir", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("stall_ov_clr", 32'(out_valid), 32'd0);
    check("stall_ir_set", 32'(in_ready), 32'd1);

    // Back-to-back with in_valid and out_ready held high.
    a = 4'd5; b = 4'd6; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    wait_valid(lat);
    check("b2b1_lat", 32'(lat), 32'(W));
    check("b2b1_prod", 32'(product), 32'd30);
    a = 4'd9; b = 4'd11;
    @(posedge clk); #1;
    check("b2b_hs_ov", 32'(out_valid), 32'd0);
    check("b2b_hs_ir", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    check("b2b_acc2", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    wait_valid(lat);
    check("b2b2_lat", 32'(lat), 32'(W));
    check("b2b2_prod", 32'(product), 32'd99);
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("b2b2_ov_clr", 32'(out_valid), 32'd0);

    // Reset mid-operation aborts and clears everything.
    a = 4'd12; b = 4'd13; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    check("mid_rst_ir", 32'(in_ready), 32'd1);
    check("mid_rst_ov", 32'(out_valid), 32'd0);
    check("mid_rst_prod", 32'(product), 32'd0);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    do_mul(4'd2, 4'd3, 8'd6);

    // Zero operand.
    do_mul(4'd0, 4'd9, 8'd0);

    // Exhaustive sweep.
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        do_mul(W'(i), W'(j), 8'(i * j));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
